// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sharing of one L2 port between the I and D L1s.
// A granted request is latched and held on the L2 port until l2_resp.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  state_t            state_n;
  logic              owner;
  logic              last_grant;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              req_write;
  logic              i_pend;
  logic              d_pend;
  logic              grant;
  logic              win_d;
  logic              busy;

  // owner/last_grant encoding: 0 = I side, 1 = D side
  always_comb begin
    i_pend  = i_read | i_write;
    d_pend  = d_read | d_write;
    grant   = 1'b0;
    win_d   = 1'b0;
    state_n = state;
    unique case (state)
      IDLE: begin
        grant = i_pend | d_pend;
        win_d = d_pend & (~i_pend | ~last_grant);
        if (grant) state_n = BUSY;
      end
      BUSY: begin
        if (l2_resp) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner      <= win_d;
        last_grant <= win_d;
        req_addr   <= win_d ? d_address : i_address;
        req_wdata  <= win_d ? d_wdata : i_wdata;
        req_write  <= win_d ? d_write : i_write;
      end
    end
  end

  always_comb begin
    busy       = (state == BUSY);
    l2_address = req_addr;
    l2_wdata   = req_wdata;
    l2_read    = busy & ~req_write;
    l2_write   = busy & req_write;
    i_resp     = busy & l2_resp & ~owner;
    d_resp     = busy & l2_resp & owner;
    i_rdata    = l2_rdata;
    d_rdata    = l2_rdata;
  end

endmodule
